// File: rtl/nibble_add_seq.sv
// nibble_add_seq: performs a 4*NIBBLES-bit add by stepping one external 4-bit
// ripple-carry slice through the operands, least significant nibble first.
// The start/busy/done handshake wraps one addition per NIBBLES+2 cycles.
module nibble_add_seq #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   ovf,
  output logic                   add_en,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_s,
  input  logic                   add_cout
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IdxW = $clog2(NIBBLES);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q;
  logic [IdxW-1:0] idx_q;
  logic            carry_q;
  logic [W-1:0]    op_a_q;
  logic [W-1:0]    op_b_q;
  logic [W-1:0]    acc_q;

  logic [IdxW+1:0] base;
  logic [W-1:0]    acc_merged;
  logic            last;

  // Bit offset of the current nibble and the accumulator with it merged in.
  always_comb begin
    base       = {idx_q, 2'b00};
    acc_merged = acc_q;
    acc_merged[base +: 4] = add_s;
    last       = (idx_q == IdxW'(NIBBLES - 1));
  end

  // Slice drive decoded from registered state only; quiet outside RUN.
  always_comb begin
    add_en  = 1'b0;
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    if (state_q == StRun) begin
      add_en  = 1'b1;
      add_a   = op_a_q[base +: 4];
      add_b   = op_b_q[base +: 4];
      add_cin = carry_q;
    end
  end

  // Sequencer FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      acc_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_a_q  <= a;
            op_b_q  <= b;
            carry_q <= cin;
            idx_q   <= '0;
            busy    <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          acc_q   <= acc_merged;
          carry_q <= add_cout;
          if (last) begin
            // Publish only once the top nibble is in; earlier nibbles never leak out.
            sum     <= acc_merged;
            cout    <= add_cout;
            ovf     <= (op_a_q[W-1] == op_b_q[W-1]) && (add_s[3] != op_a_q[W-1]);
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_add_seq.sv
// Bench for nibble_add_seq: a behavioural 4-bit slice on the add_* ports, an
// arithmetic reference model feeding a scoreboard queue, and a monitor that
// checks handshake timing, slice drive and results every cycle.
module tb_nibble_add_seq;

  localparam int unsigned N = 4;
  localparam int unsigned W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;
  logic         add_en, add_cin, add_cout;
  logic [3:0]   add_a, add_b, add_s;
  logic [4:0]   slice_res;

  int checks   = 0;
  int failures = 0;

  nibble_add_seq #(.NIBBLES(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf),
    .add_en   (add_en),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_s    (add_s),
    .add_cout (add_cout)
  );

  // Behavioural 4-bit adder slice.
  assign slice_res = 5'(add_a) + 5'(add_b) + 5'(add_cin);
  assign add_s     = slice_res[3:0];
  assign add_cout  = slice_res[4];

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state.
  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           due;
  } exp_t;

  exp_t         q[$];
  int           cyc     = 0;
  int           e0      = -100;
  int           free_at = 0;
  logic [W-1:0] ma = '0, mb = '0;
  logic         mc = 1'b0;
  logic [W-1:0] held_s = '0;
  logic         held_c = 1'b0, held_o = 1'b0;

  // Model: accept a request when idle by the handshake rules; compute result arithmetically.
  initial begin
    forever begin
      logic [W:0] full;
      exp_t       e;
      @(posedge clk);
      cyc++;
      if (rst_n && start && cyc >= free_at) begin
        e0      = cyc;
        ma      = a;
        mb      = b;
        mc      = cin;
        full    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        e.s     = full[W-1:0];
        e.c     = full[W];
        e.o     = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        e.due   = cyc + N;
        q.push_back(e);
        free_at = cyc + N + 2;
      end
    end
  end

  // Model: asynchronous reset discards any addition in flight.
  initial begin
    forever begin
      @(negedge rst_n);
      e0      = -100;
      free_at = 0;
      q.delete();
      held_s  = '0;
      held_c  = 1'b0;
      held_o  = 1'b0;
    end
  end

  // Monitor: sample on the falling edge and compare against the model.
  initial begin
    forever begin
      logic        exp_busy, exp_done;
      int          k;
      logic [63:0] mask, ea, eb, ec;
      exp_t        e;
      @(negedge clk);
      exp_busy = (e0 <= cyc) && (cyc < e0 + int'(N));
      exp_done = (cyc == e0 + int'(N));
      chk("busy", busy, exp_busy);
      chk("done", done, exp_done);
      chk("add_en", add_en, exp_busy);
      if (exp_busy) begin
        k    = cyc - e0;
        mask = (64'd1 << (4 * k)) - 64'd1;
        ea   = (64'(ma) >> (4 * k)) & 64'hF;
        eb   = (64'(mb) >> (4 * k)) & 64'hF;
        ec   = (((64'(ma) & mask) + (64'(mb) & mask) + 64'(mc)) >> (4 * k)) & 64'd1;
        chk("add_a", add_a, ea);
        chk("add_b", add_b, eb);
        chk("add_cin", add_cin, ec);
      end else begin
        chk("slice_idle", {add_a, add_b, add_cin}, 64'd0);
      end
      if (done) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL done_queued: got done with no pending request, expected none (t=%0t)",
                   $time);
        end else begin
          e = q.pop_front();
          chk("sum", sum, e.s);
          chk("cout", cout, e.c);
          chk("ovf", ovf, e.o);
          chk("latency", cyc, e.due);
          held_s = e.s;
          held_c = e.c;
          held_o = e.o;
        end
      end
      chk("hold", {sum, cout, ovf}, {held_s, held_c, held_o});
    end
  end

  // One accepted request from idle, then a direct check against a known answer.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input logic [W-1:0] es, input logic ec, input logic eo);
    a = ta; b = tb; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    repeat (N) @(posedge clk);
    #1;
    chk("known_sum", sum, es);
    chk("known_cout", cout, ec);
    chk("known_ovf", ovf, eo);
    @(posedge clk); #1;
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return {W{1'b1}};
      1:       return {1'b1, {(W-1){1'b0}}};
      2:       return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    rst_n = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", {busy, done, sum, cout, ovf, add_en, add_a, add_b, add_cin}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op(16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
    run_op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);

    // Start pulses during RUN and DONE must be ignored.
    a = 16'h0005; b = 16'h0005; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    a = 16'h00FF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("busy_ignore_sum", sum, 16'h000A);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset after two RUN cycles.
    a = 16'h0006; b = 16'h0006; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_sum", sum, 16'h0000);
    chk("midrst_add_en", add_en, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    run_op(16'h0006, 16'h0006, 1'b0, 16'h000C, 1'b0, 1'b0);

    // Back-to-back: start held high with operands changing every cycle.
    start = 1'b1;
    repeat (30) begin
      a = rnd_op(); b = rnd_op(); cin = 1'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // Random traffic, including requests that land while busy.
    repeat (400) begin
      start = ($urandom_range(0, 2) == 0);
      a = rnd_op(); b = rnd_op(); cin = 1'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
